host_wg_responder: RTL

GPU-side responder for the host work-group launch protocol. Accepts work-group descriptors from the host over the valid/ready request channel, queues them in a request FIFO, and dispatches them in order to the workgroup allocator. It collects completion pulses from the allocator and returns each completed work-group ID to the host over the valid/ready response channel, throttling new requests so that completions can never be dropped.

---
 rtl/host_wg_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/host_wg_responder.sv
// host_wg_responder: accepts work-group descriptors from the host, queues them
// for the workgroup allocator in strict order, and returns completed work-group
// IDs to the host in completion-arrival order. New requests are throttled on the
// in-flight count so that the completion queue can never overflow.
module host_wg_responder #(
  parameter int WG_ID_WIDTH  = 5,
  parameter int DESC_WIDTH   = 256,
  parameter int REQ_DEPTH    = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int CPL_DEPTH    = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             host_req_valid_i,
  output logic                             host_req_ready_o,
  input  logic [WG_ID_WIDTH-1:0]           host_req_wg_id_i,
  input  logic [DESC_WIDTH-1:0]            host_req_desc_i,
  output logic                             disp_valid_o,
  input  logic                             disp_ready_i,
  output logic [WG_ID_WIDTH-1:0]           disp_wg_id_o,
  output logic [DESC_WIDTH-1:0]            disp_desc_o,
  input  logic                             done_valid_i,
  input  logic [WG_ID_WIDTH-1:0]           done_wg_id_i,
  output logic                             host_rsp_valid_o,
  input  logic                             host_rsp_ready_i,
  output logic [WG_ID_WIDTH-1:0]           host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt_o,
  output logic                             err_o
);

  localparam int RPW = $clog2(REQ_DEPTH);
  localparam int CPW = $clog2(CPL_DEPTH);
  localparam int CW  = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] MAX_INF_C = CW'(MAX_INFLIGHT);

  // Request queue storage and pointers (extra MSB is the wrap bit)
  logic [WG_ID_WIDTH-1:0] req_id_mem_r   [REQ_DEPTH];
  logic [DESC_WIDTH-1:0]  req_desc_mem_r [REQ_DEPTH];
  logic [RPW:0]           req_wr_ptr_r;
  logic [RPW:0]           req_rd_ptr_r;

  // Completion queue storage and pointers
  logic [WG_ID_WIDTH-1:0] cpl_id_mem_r [CPL_DEPTH];
  logic [CPW:0]           cpl_wr_ptr_r;
  logic [CPW:0]           cpl_rd_ptr_r;

  logic [CW-1:0]          inflight_r;
  logic                   err_r;

  logic                   req_full_s;
  logic                   req_empty_s;
  logic                   cpl_full_s;
  logic                   cpl_empty_s;
  logic                   req_push_s;
  logic                   req_pop_s;
  logic                   cpl_push_s;
  logic                   cpl_pop_s;
  logic [CPW:0]           cpl_occ_s;
  logic [31:0]            inflight_ext_s;
  logic [31:0]            cpl_occ_ext_s;
  logic                   no_pending_s;

  assign req_full_s  = (req_wr_ptr_r[RPW] != req_rd_ptr_r[RPW]) &&
                       (req_wr_ptr_r[RPW-1:0] == req_rd_ptr_r[RPW-1:0]);
  assign req_empty_s = (req_wr_ptr_r == req_rd_ptr_r);
  assign cpl_full_s  = (cpl_wr_ptr_r[CPW] != cpl_rd_ptr_r[CPW]) &&
                       (cpl_wr_ptr_r[CPW-1:0] == cpl_rd_ptr_r[CPW-1:0]);
  assign cpl_empty_s = (cpl_wr_ptr_r == cpl_rd_ptr_r);

  // Ready depends only on registered state, never on the host's valid
  assign host_req_ready_o = !req_full_s && (inflight_r < MAX_INF_C);
  assign disp_valid_o     = !req_empty_s;
  assign host_rsp_valid_o = !cpl_empty_s;
  assign disp_wg_id_o     = req_id_mem_r[req_rd_ptr_r[RPW-1:0]];
  assign disp_desc_o      = req_desc_mem_r[req_rd_ptr_r[RPW-1:0]];
  assign host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o = cpl_id_mem_r[cpl_rd_ptr_r[CPW-1:0]];
  assign inflight_cnt_o   = inflight_r;
  assign err_o            = err_r;

  assign req_push_s = host_req_valid_i && host_req_ready_o;
  assign req_pop_s  = disp_valid_o && disp_ready_i;
  assign cpl_push_s = done_valid_i && !cpl_full_s;
  assign cpl_pop_s  = host_rsp_valid_o && host_rsp_ready_i;

  // Pending completions = inflight - completion occupancy; none pending means a
  // done pulse is unexpected (<= also catches a queue already holding spurious entries)
  assign cpl_occ_s      = cpl_wr_ptr_r - cpl_rd_ptr_r;
  assign inflight_ext_s = {{(32-CW){1'b0}}, inflight_r};
  assign cpl_occ_ext_s  = {{(32-CPW-1){1'b0}}, cpl_occ_s};
  assign no_pending_s   = (inflight_ext_s <= cpl_occ_ext_s);

  // Request queue: write on host accept, advance read on allocator handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wr_ptr_r <= '0;
      req_rd_ptr_r <= '0;
      for (int i = 0; i < REQ_DEPTH; i++) begin
        req_id_mem_r[i]   <= '0;
        req_desc_mem_r[i] <= '0;
      end
    end else begin
      if (req_push_s) begin
        req_id_mem_r[req_wr_ptr_r[RPW-1:0]]   <= host_req_wg_id_i;
        req_desc_mem_r[req_wr_ptr_r[RPW-1:0]] <= host_req_desc_i;
        req_wr_ptr_r <= req_wr_ptr_r + 1'b1;
      end
      if (req_pop_s) begin
        req_rd_ptr_r <= req_rd_ptr_r + 1'b1;
      end
    end
  end

  // Completion queue: capture done pulses, advance read on host handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpl_wr_ptr_r <= '0;
      cpl_rd_ptr_r <= '0;
      for (int i = 0; i < CPL_DEPTH; i++) begin
        cpl_id_mem_r[i] <= '0;
      end
    end else begin
      if (cpl_push_s) begin
        cpl_id_mem_r[cpl_wr_ptr_r[CPW-1:0]] <= done_wg_id_i;
        cpl_wr_ptr_r <= cpl_wr_ptr_r + 1'b1;
      end
      if (cpl_pop_s) begin
        cpl_rd_ptr_r <= cpl_rd_ptr_r + 1'b1;
      end
    end
  end

  // In-flight count: up on accept, down on response, unchanged when both;
  // never wraps below zero if a spurious completion is returned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= '0;
    end else if (req_push_s && !cpl_pop_s) begin
      inflight_r <= inflight_r + 1'b1;
    end else if (cpl_pop_s && !req_push_s && (inflight_r != '0)) begin
      inflight_r <= inflight_r - 1'b1;
    end else begin
      inflight_r <= inflight_r;
    end
  end

  // Sticky error on a dropped or unexpected completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (done_valid_i && (cpl_full_s || no_pending_s)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule
